// File: rtl/fp_add_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_add_pkg
// Brief  : FP32 field widths, pre-decoded operand entry type, classifier
//          helpers for the FP32 adder operand stage.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package fp_add_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int MAG_W  = EXP_W + MANT_W;
  localparam int FP_W   = MAG_W + 1;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  // One queued entry: magnitude-ordered operands plus bypass result.
  typedef struct packed {
    logic [MAG_W-1:0] l;
    logic [MAG_W-1:0] s;
    logic             sl;
    logic             ss;
    logic [EXP_W-1:0] d;
    logic [EXP_W-1:0] e;
    logic             bypass;
    logic [FP_W-1:0]  res;
  } op_entry_t;

  // Denormals are flushed to zero, keeping the sign.
  function automatic logic [FP_W-1:0] fp_flush(input logic [FP_W-1:0] x);
    if (x[MAG_W-1:MANT_W] == '0) return {x[FP_W-1], {MAG_W{1'b0}}};
    return x;
  endfunction

  // Class of an already-flushed operand.
  function automatic fp_class_t fp_classify(input logic [FP_W-1:0] x);
    if (x[MAG_W-1:MANT_W] == EXP_MAX) begin
      if (x[MANT_W-1:0] != '0) return NAN;
      return INF;
    end
    if (x[MAG_W-1:MANT_W] == '0) return ZERO;
    return NORM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_operand_stage_swap.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_swap_classify
// Brief  : Combinational operand ordering and IEEE special-case resolution
//          for one FP32 operand pair.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module fp_swap_classify
  import fp_add_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output op_entry_t       entry_o
);

  logic [FP_W-1:0] fa;
  logic [FP_W-1:0] fb;
  fp_class_t       ca;
  fp_class_t       cb;
  logic            a_larger;
  logic [FP_W-1:0] big;
  logic [FP_W-1:0] sml;

  assign fa = fp_flush(a_i);
  assign fb = fp_flush(b_i);
  assign ca = fp_classify(fa);
  assign cb = fp_classify(fb);

  // On an exact magnitude tie operand a is treated as the larger one.
  assign a_larger = (fa[MAG_W-1:0] >= fb[MAG_W-1:0]);
  assign big      = a_larger ? fa : fb;
  assign sml      = a_larger ? fb : fa;

  // Build the entry: ordered fields, exponent gap, then special-case override.
  always_comb begin
    entry_o        = '0;
    entry_o.l      = big[MAG_W-1:0];
    entry_o.s      = sml[MAG_W-1:0];
    entry_o.sl     = big[FP_W-1];
    entry_o.ss     = sml[FP_W-1];
    entry_o.e      = big[MAG_W-1:MANT_W];
    entry_o.d      = big[MAG_W-1:MANT_W] - sml[MAG_W-1:MANT_W];
    entry_o.bypass = 1'b1;
    entry_o.res    = '0;
    if (ca == NAN || cb == NAN) begin
      entry_o.res = QNAN;
    end else if (ca == INF && cb == INF && fa[FP_W-1] != fb[FP_W-1]) begin
      entry_o.res = QNAN;
    end else if (ca == INF) begin
      entry_o.res = fa;
    end else if (cb == INF) begin
      entry_o.res = fb;
    end else if (ca == ZERO && cb == ZERO) begin
      entry_o.res = {fa[FP_W-1] & fb[FP_W-1], {MAG_W{1'b0}}};
    end else if (ca == ZERO) begin
      entry_o.res = fb;
    end else if (cb == ZERO) begin
      entry_o.res = fa;
    end else begin
      entry_o.bypass = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_add_operand_stage
// Brief  : Registered issue stage ahead of the FP32 adder. Decodes operand
//          pairs at push time and buffers DEPTH entries in a FIFO.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module fp_add_operand_stage
  import fp_add_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_l,
  output logic [MAG_W-1:0] out_s,
  output logic             out_sl,
  output logic             out_ss,
  output logic [EXP_W-1:0] out_d,
  output logic [EXP_W-1:0] out_e,
  output logic             out_bypass,
  output logic [FP_W-1:0]  out_res
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  op_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  op_entry_t        push_entry;
  op_entry_t        head;
  logic             push;
  logic             pop;

  fp_swap_classify u_swap (
    .a_i     (in_a),
    .b_i     (in_b),
    .entry_o (push_entry)
  );

  // Ready depends only on stored occupancy, never on out_ready.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers and occupancy; pointers wrap naturally (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads all-zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_l      = head.l;
  assign out_s      = head.s;
  assign out_sl     = head.sl;
  assign out_ss     = head.ss;
  assign out_d      = head.d;
  assign out_e      = head.e;
  assign out_bypass = head.bypass;
  assign out_res    = head.res;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_fp_add_operand_stage
// Brief  : Self-checking bench: directed vectors, FIFO ordering, reset
//          behaviour and randomized traffic against a queue-based model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_fp_add_operand_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] out_l;
  logic [30:0] out_s;
  logic        out_sl;
  logic        out_ss;
  logic [7:0]  out_d;
  logic [7:0]  out_e;
  logic        out_bypass;
  logic [31:0] out_res;

  logic [127:0] dut_entry;
  logic [127:0] mq[$];
  int           n_assert = 0;
  int           n_fail = 0;

  fp_add_operand_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_l      (out_l),
    .out_s      (out_s),
    .out_sl     (out_sl),
    .out_ss     (out_ss),
    .out_d      (out_d),
    .out_e      (out_e),
    .out_bypass (out_bypass),
    .out_res    (out_res)
  );

  always #5 clk = ~clk;

  assign dut_entry = {15'd0, out_l, out_s, out_sl, out_ss, out_d, out_e, out_bypass, out_res};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [30:0] l, input logic [30:0] s,
                                       input logic sl, input logic ss, input logic [7:0] d,
                                       input logic [7:0] e, input logic byp, input logic [31:0] res);
    return {15'd0, l, s, sl, ss, d, e, byp, res};
  endfunction

  // Reference: IEEE-style decisions written directly from the rules.
  function automatic logic [127:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] fa, fb, big, sml, res;
    int unsigned ma, mb;
    int          gap;
    logic        nan_a, nan_b, inf_a, inf_b, z_a, z_b, byp;
    fa = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
    fb = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
    ma = int'(fa[30:0]);
    mb = int'(fb[30:0]);
    if (ma >= mb) begin big = fa; sml = fb; end
    else          begin big = fb; sml = fa; end
    gap   = int'(big[30:23]) - int'(sml[30:23]);
    nan_a = (fa[30:23] == 8'hFF) && (fa[22:0] != 0);
    nan_b = (fb[30:23] == 8'hFF) && (fb[22:0] != 0);
    inf_a = (ma == 32'h7F80_0000);
    inf_b = (mb == 32'h7F80_0000);
    z_a   = (ma == 0);
    z_b   = (mb == 0);
    byp   = 1'b1;
    res   = 32'd0;
    if (nan_a || nan_b)                       res = 32'h7FC0_0000;
    else if (inf_a && inf_b && fa[31] != fb[31]) res = 32'h7FC0_0000;
    else if (inf_a)                           res = fa;
    else if (inf_b)                           res = fb;
    else if (z_a && z_b)                      res = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    else if (z_a)                             res = b;
    else if (z_b)                             res = a;
    else                                      byp = 1'b0;
    return mk(big[30:0], sml[30:0], big[31], sml[31], 8'(gap), big[30:23], byp, res);
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       return {s, 31'd0};
      1:       return {s, 8'd0, 23'($urandom_range(1, 32'h7F_FFFF))};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // One clock: drive, check against model before the edge, update model at the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    logic do_push, do_pop;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    @(negedge clk);
    check("in_ready", 128'(in_ready), 128'(mq.size() < DEPTH));
    check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) check("head", dut_entry, mq[0]);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(model(a, b));
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [127:0] exp);
    step(1'b1, a, b, 1'b0);
    in_valid = 1'b0;
    check(tag, dut_entry, exp);
    step(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] a, b;
    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_fields", dut_entry, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    directed("vec_basic", 32'h4000_0000, 32'h3F80_0000,
             mk(31'h4000_0000, 31'h3F80_0000, 1'b0, 1'b0, 8'd1, 8'h80, 1'b0, 32'd0));
    directed("vec_swap", 32'h3F80_0000, 32'hC040_0000,
             mk(31'h4040_0000, 31'h3F80_0000, 1'b1, 1'b0, 8'd1, 8'h80, 1'b0, 32'd0));
    directed("vec_inf_inf", 32'h7F80_0000, 32'hFF80_0000,
             mk(31'h7F80_0000, 31'h7F80_0000, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b1, 32'h7FC0_0000));
    directed("vec_nan", 32'hFFC0_0001, 32'h0000_0000,
             mk(31'h7FC0_0001, 31'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 32'h7FC0_0000));
    directed("vec_negzero", 32'h8000_0000, 32'h8000_0000,
             mk(31'd0, 31'd0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 32'h8000_0000));
    directed("vec_denorm", 32'h0000_0001, 32'h3F80_0000,
             mk(31'h3F80_0000, 31'd0, 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b1, 32'h3F80_0000));

    // Back-pressure: P2 held while full, then strict FIFO drain
    step(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    step(1'b1, 32'h3F80_0000, 32'hC040_0000, 1'b0);
    step(1'b1, 32'h4100_0000, 32'h4080_0000, 1'b0);
    step(1'b1, 32'h4100_0000, 32'h4080_0000, 1'b0);
    step(1'b1, 32'h4100_0000, 32'h4080_0000, 1'b1);
    step(1'b1, 32'h4100_0000, 32'h4080_0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Reset while full
    step(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    step(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0);
    in_valid = 1'b0;
    check("full_in_ready", 128'(in_ready), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready), 128'd1);
    check("rst_mid_fields", dut_entry, 128'd0);
    mq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 32'hC000_0000, 32'h4080_0000, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), a[30:0]} : rand_op();
      step(1'($urandom_range(0, 3) != 0), a, b, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'd0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
